pit8253_bus_master: RTL and testbench
=====================================

Name: pit8253_bus_master

Overview:
- CPU-side initiator that programs and reads back the pit8253 timer over its a/wr/rd/din/dout bus.
- Accepts high-level commands: "program channel N with mode M and divisor D", or "latch and read channel N".
- Expands each command into the exact 8253 byte sequence, with strobe widths long enough to span a timer clock-enable.
- Sits between the sound/system controller logic and the timer; replaces hand-written CPU I/O sequences.

Parameters:
- STROBE_CYCLES, 2, minimum clk cycles a wr/rd strobe stays high.
- GAP_CYCLES, 2, clk cycles with strobes low between bus operations (a/din held during the first of them).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tce  in  1  timer clock enable, same signal as fed to the timer
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
- cmd_op  in  1  0=program, 1=read
- cmd_ch  in  2  channel 0..2; 3 is illegal
- cmd_rl  in  2  read/load mode 01=LSB, 10=MSB, 11=LSB then MSB; 00 is illegal
- cmd_mode  in  3  counter mode 0..5 (program only)
- cmd_value  in  16  divisor (program only)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  valid with rsp_valid; illegal command
- rsp_data  out  16  read result; 0 for program or error
- pit_a  out  2  timer address
- pit_wr  out  1  timer write strobe
- pit_rd  out  1  timer read strobe
- pit_din  out  8  data to timer
- pit_dout  in  8  data from timer

Behaviour:
- Reset (async, while reset_n=0):
  - FSM goes to IDLE; pit_wr, pit_rd, rsp_valid, rsp_err = 0; pit_a, pit_din, rsp_data = 0.
  - Any operation in flight is abandoned with no response.
  - cmd_ready = 1 from the first clk after release.
- Accept: command fields are captured into registers on the accepting edge.
  - ch=3, or rl=00, yields an error: rsp_valid=1 and rsp_err=1 on the next cycle, no bus activity, return to IDLE.
- Program sequence:
  - Bus op 1: write a=3, din = {ch, rl, mode, 1'b0} (binary count only).
  - Then by rl: 01 writes a=ch, value[7:0]; 10 writes a=ch, value[15:8]; 11 writes value[7:0], then value[15:8].
- Read sequence:
  - Bus op 1: write a=3, din = {ch, 2'b00, 4'b0000} (latch command).
  - Then reads from a=ch by rl: 11 reads LSB then MSB into rsp_data[7:0] then [15:8]; 01 reads one byte into [7:0], [15:8]=0; 10 reads one byte into [15:8], [7:0]=0.
- rl semantics: the caller must pass the rl the channel was last programmed with. The block does no cross-command tracking.
- Bus operation FSM: IDLE -> SETUP -> STROBE -> GAP -> (SETUP of next op | RESP) -> IDLE.
  - SETUP (1 cycle): pit_a and pit_din are driven; strobes low.
  - STROBE: pit_wr or pit_rd = 1.
    - Exit only when at least STROBE_CYCLES have elapsed AND a tce=1 was sampled while the strobe was high (sticky tce_seen flag, cleared in SETUP).
    - Reads sample pit_dout on the last STROBE cycle.
  - GAP: strobes low for GAP_CYCLES. pit_a and pit_din are unchanged through the first GAP cycle.
  - RESP (1 cycle): rsp_valid=1 with rsp_err=0.
- Latency with tce held at 1: op time = 1 + STROBE_CYCLES + GAP_CYCLES; response at accept + n_ops × op time + 1.
  - With defaults and rl=11 (3 ops): rsp_valid 16 cycles after accept.
- pit_wr and pit_rd are never high together. A strobe never rises in the same cycle a/din change.
- cmd_valid while busy is ignored; the command fields are not re-sampled.
- rsp_data holds its value until the next response.
- A tce seen during SETUP or GAP does not count toward tce_seen.

Decomposition:
- Shared package pit_pkg:
  - FSM state encoding.
  - A_CW=2'b11.
  - RL_LSB/RL_MSB/RL_WORD/RL_LATCH codes.
  - Mode constants M0..M5.
  - OP_PROG/OP_READ.
- Sub-module pit_strobe_timer: counts STROBE_CYCLES/GAP_CYCLES, tracks tce_seen, and emits strobe_done/gap_done to the sequencing FSM.

Test Plan:
- Program ch2, mode3, rl=11, value 16'h1234, tce=1 -> writes (3,8'hB6), (2,8'h34), (2,8'h12); rsp_valid at cycle 16 with err=0, data=0; the attached pit8253 counter_load for ch2 = 16'h1234 and out[2] toggles.
- tce pulsed once every 8 clk, program ch0, mode2, rl=01, value 8'h05 -> each wr stays high until a tce is sampled (width ≥2, ≤9 cycles); bus shows (3,8'h14), (0,8'h05).
- After programming ch1 with rl=11 value 16'h0100 (mode2), read ch1 rl=11 -> latch write (3,8'h40), two reads; rsp_data equals the timer value latched at the latch strobe (bench reference model), LSB/MSB assembled correctly.
- cmd_ch=3, or cmd_rl=00 -> no strobes; rsp_valid and rsp_err=1 one cycle after accept; cmd_ready back to 1 on the next cycle.
- reset_n asserted mid-STROBE of a program command -> pit_wr=0 immediately (async), no rsp_valid; a new command after release completes normally.
- cmd_valid held high with changing fields during a busy period -> only the first command executes; the next command is accepted only once cmd_ready=1 again.

Source files
------------

// File: rtl/pit8253_bus_master_pkg.sv
// pit_pkg: shared FSM encoding and 8253 bus constants for the pit8253 bus master.
package pit_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ERR, S_SETUP, S_STROBE, S_GAP, S_RESP} state_t;
    localparam logic [1:0] A_CW = 2'b11;
    localparam logic [1:0] RL_LATCH = 2'b00;
    localparam logic [1:0] RL_LSB = 2'b01;
    localparam logic [1:0] RL_MSB = 2'b10;
    localparam logic [1:0] RL_WORD = 2'b11;
    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;
    localparam logic OP_PROG = 1'b0;
    localparam logic OP_READ = 1'b1;
    function automatic logic illegal(input logic [1:0] ch, input logic [1:0] rl);
        return ch == 2'd3 || rl == RL_LATCH;
    endfunction
endpackage

// File: rtl/pit8253_bus_master_if.sv
// pit8253_bus_master_if: command/response handshake plus the 8253 a/wr/rd/din/dout bus.
interface pit8253_bus_master_if;
    logic cmd_valid, cmd_ready, cmd_op;
    logic [1:0] cmd_ch, cmd_rl;
    logic [2:0] cmd_mode;
    logic [15:0] cmd_value;
    logic rsp_valid, rsp_err;
    logic [15:0] rsp_data;
    logic [1:0] pit_a;
    logic pit_wr, pit_rd;
    logic [7:0] pit_din, pit_dout;
    modport master(
        input cmd_valid, cmd_op, cmd_ch, cmd_rl, cmd_mode, cmd_value, pit_dout,
        output cmd_ready, rsp_valid, rsp_err, rsp_data, pit_a, pit_wr, pit_rd, pit_din
    );
    modport slave(
        output cmd_valid, cmd_op, cmd_ch, cmd_rl, cmd_mode, cmd_value, pit_dout,
        input cmd_ready, rsp_valid, rsp_err, rsp_data, pit_a, pit_wr, pit_rd, pit_din
    );
endinterface

// File: rtl/pit8253_bus_master_strobe_timer.sv
// pit_strobe_timer: times strobe/gap phases; a strobe ends only after its minimum width
// and once a timer clock-enable has been seen while it was high.
module pit_strobe_timer #(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tce,
    input  logic setup,
    input  logic strobe,
    input  logic gap,
    output logic strobe_done,
    output logic gap_done
);
    localparam int W = $clog2(STROBE_CYCLES + GAP_CYCLES + 1);
    logic [W-1:0] cnt;
    logic tce_seen;
    assign strobe_done = strobe && cnt == W'(STROBE_CYCLES - 1) && (tce_seen || tce);
    assign gap_done = gap && cnt == W'(GAP_CYCLES - 1);
    // the strobe count saturates so a long wait for tce cannot wrap it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            tce_seen <= 1'b0;
        end else begin
            cnt <= (setup || strobe_done || gap_done) ? '0 :
                   ((strobe && cnt != W'(STROBE_CYCLES - 1)) || gap) ? cnt + 1'b1 : cnt;
            tce_seen <= setup ? 1'b0 : tce_seen | (strobe & tce);
        end
    end
endmodule

// File: rtl/pit8253_bus_master.sv
// pit8253_bus_master: expands program/read commands into 8253 control-word and
// data byte sequences with tce-safe strobe widths.
module pit8253_bus_master
    import pit_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES = 2
) (
    input logic clk,
    input logic reset_n,
    input logic tce,
    pit8253_bus_master_if.master bus
);
    state_t state, nxt;
    logic op;
    logic [1:0] ch, rl, idx;
    logic [2:0] mode;
    logic [15:0] value, buffer;
    logic strobe_done, gap_done, last, hi, rd_op, on_bus;
    logic [7:0] din_op;

    pit_strobe_timer #(.STROBE_CYCLES(STROBE_CYCLES), .GAP_CYCLES(GAP_CYCLES)) u_timer (
        .clk(clk),
        .reset_n(reset_n),
        .tce(tce),
        .setup(state == S_SETUP),
        .strobe(state == S_STROBE),
        .gap(state == S_GAP),
        .strobe_done(strobe_done),
        .gap_done(gap_done)
    );

    // op 0 is always the control word; ops 1..2 address the channel itself
    always_comb begin
        last = idx == (rl == RL_WORD ? 2'd2 : 2'd1);
        hi = rl == RL_MSB || idx == 2'd2;
        rd_op = op == OP_READ && idx != 2'd0;
        on_bus = state inside {S_SETUP, S_STROBE, S_GAP};
        din_op = idx == 2'd0 ? (op == OP_PROG ? {ch, rl, mode, 1'b0} : {ch, RL_LATCH, 4'b0000}) :
                 op == OP_READ ? 8'h00 : hi ? value[15:8] : value[7:0];
        bus.pit_a = on_bus ? (idx == 2'd0 ? A_CW : ch) : 2'd0;
        bus.pit_din = on_bus ? din_op : 8'h00;
        bus.pit_wr = state == S_STROBE && !rd_op;
        bus.pit_rd = state == S_STROBE && rd_op;
        bus.cmd_ready = state == S_IDLE;
        bus.rsp_valid = state == S_RESP || state == S_ERR;
        bus.rsp_err = state == S_ERR;
        nxt = state;
        case (state)
            S_IDLE:   nxt = bus.cmd_valid ? (illegal(bus.cmd_ch, bus.cmd_rl) ? S_ERR : S_SETUP) : S_IDLE;
            S_SETUP:  nxt = S_STROBE;
            S_STROBE: nxt = strobe_done ? S_GAP : S_STROBE;
            S_GAP:    nxt = gap_done ? (last ? S_RESP : S_SETUP) : S_GAP;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            op <= OP_PROG;
            ch <= 2'd0;
            rl <= 2'd0;
            idx <= 2'd0;
            mode <= 3'd0;
            value <= 16'h0000;
            buffer <= 16'h0000;
            bus.rsp_data <= 16'h0000;
        end else begin
            state <= nxt;
            if (state == S_IDLE && bus.cmd_valid) begin
                op <= bus.cmd_op;
                ch <= bus.cmd_ch;
                rl <= bus.cmd_rl;
                mode <= bus.cmd_mode;
                value <= bus.cmd_value;
                idx <= 2'd0;
                buffer <= 16'h0000;
                if (illegal(bus.cmd_ch, bus.cmd_rl)) bus.rsp_data <= 16'h0000;
            end
            if (state == S_STROBE && strobe_done && rd_op) begin
                if (hi) buffer[15:8] <= bus.pit_dout;
                else buffer[7:0] <= bus.pit_dout;
            end
            if (state == S_GAP && gap_done) begin
                if (last) bus.rsp_data <= buffer;
                else idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pit8253_bus_master.sv
// tb_pit8253_bus_master: table-driven command vectors against a byte-level 8253 responder,
// plus reset-abort and busy-ignore sequences.
module tb_pit8253_bus_master;
    import pit_pkg::*;

    typedef struct {
        logic op;
        logic [1:0] ch, rl;
        logic [2:0] mode;
        logic [15:0] value;
        logic slow, err;
        logic [15:0] data;
        int lat, nw;
        logic [9:0] w[3];
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tce = 1'b1;
    logic tce_slow = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    vec_t vt[10];
    logic [9:0] wq[$];
    logic [15:0] cnt_val[4], lat_v[4];
    logic rptr[4];
    logic [1:0] mrl[4];
    logic wr_q = 1'b0, rd_q = 1'b0;
    int wcnt = 0;
    logic [1:0] pa = 2'd0;
    logic [7:0] pd = 8'h00;

    pit8253_bus_master_if bus();

    pit8253_bus_master #(.STROBE_CYCLES(2), .GAP_CYCLES(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .tce(tce),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always_comb bus.pit_dout = rptr[bus.pit_a] ? lat_v[bus.pit_a][15:8] : lat_v[bus.pit_a][7:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // bus watcher and 8253 responder: records writes, checks strobe shape, serves latched bytes
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                wr_q = 1'b0;
                rd_q = 1'b0;
                wcnt = 0;
            end else begin
                if ((bus.pit_wr && !wr_q) || (bus.pit_rd && !rd_q)) begin
                    check("stable_a", 32'(bus.pit_a), 32'(pa));
                    check("stable_din", 32'(bus.pit_din), 32'(pd));
                    check("no_overlap", 32'(bus.pit_wr && bus.pit_rd), 32'd0);
                end
                if (bus.pit_wr && !wr_q) begin
                    wq.push_back({bus.pit_a, bus.pit_din});
                    if (bus.pit_a == A_CW) begin
                        if (bus.pit_din[5:4] == RL_LATCH) begin
                            lat_v[bus.pit_din[7:6]] = cnt_val[bus.pit_din[7:6]];
                            rptr[bus.pit_din[7:6]] = mrl[bus.pit_din[7:6]] == RL_MSB;
                        end else mrl[bus.pit_din[7:6]] = bus.pit_din[5:4];
                    end
                end
                if (bus.pit_wr || bus.pit_rd) wcnt++;
                else if (wr_q || rd_q) begin
                    checks++;
                    if (wcnt < 2 || wcnt > 9) begin
                        errors++;
                        $display("FAIL strobe_width got %0d want 2..9", wcnt);
                    end
                    if (rd_q && mrl[bus.pit_a] == RL_WORD) rptr[bus.pit_a] = !rptr[bus.pit_a];
                    wcnt = 0;
                end
                wr_q = bus.pit_wr;
                rd_q = bus.pit_rd;
            end
            pa = bus.pit_a;
            pd = bus.pit_din;
        end
    endtask

    task automatic drive(input logic op, input logic [1:0] ch, input logic [1:0] rl,
                         input logic [2:0] mode, input logic [15:0] value);
        bus.cmd_op = op;
        bus.cmd_ch = ch;
        bus.cmd_rl = rl;
        bus.cmd_mode = mode;
        bus.cmd_value = value;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("rsp_seen", 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic run_vec(input int i);
        int lat, n;
        tce_slow = vt[i].slow;
        wq.delete();
        @(posedge clk);
        #1;
        drive(vt[i].op, vt[i].ch, vt[i].rl, vt[i].mode, vt[i].value);
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_rsp(lat);
        check($sformatf("v%0d_err", i), 32'(bus.rsp_err), 32'(vt[i].err));
        check($sformatf("v%0d_data", i), 32'(bus.rsp_data), 32'(vt[i].data));
        if (vt[i].lat != 0) check($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
        @(posedge clk);
        #1;
        check($sformatf("v%0d_ready_after", i), 32'(bus.cmd_ready), 32'd1);
        check($sformatf("v%0d_rsp_pulse", i), 32'(bus.rsp_valid), 32'd0);
        check($sformatf("v%0d_data_hold", i), 32'(bus.rsp_data), 32'(vt[i].data));
        check($sformatf("v%0d_nwrites", i), 32'(wq.size()), 32'(vt[i].nw));
        for (int j = 0; j < vt[i].nw; j++)
            check($sformatf("v%0d_write%0d", i, j), j < wq.size() ? 32'(wq[j]) : 32'hFFFF, 32'(vt[i].w[j]));
    endtask

    initial begin
        int lat, n, pulses;
        cnt_val = '{16'h5A3C, 16'hBEEF, 16'h7788, 16'h0000};
        lat_v = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        rptr = '{1'b0, 1'b0, 1'b0, 1'b0};
        mrl = '{RL_WORD, RL_WORD, RL_WORD, RL_WORD};
        vt[0] = '{OP_PROG, 2'd2, RL_WORD, M3, 16'h1234, 1'b0, 1'b0, 16'h0000, 16, 3, '{{2'd3, 8'hB6}, {2'd2, 8'h34}, {2'd2, 8'h12}}};
        vt[1] = '{OP_PROG, 2'd0, RL_LSB, M2, 16'h0005, 1'b1, 1'b0, 16'h0000, 0, 2, '{{2'd3, 8'h14}, {2'd0, 8'h05}, 10'h0}};
        vt[2] = '{OP_PROG, 2'd1, RL_WORD, M2, 16'h0100, 1'b0, 1'b0, 16'h0000, 16, 3, '{{2'd3, 8'h74}, {2'd1, 8'h00}, {2'd1, 8'h01}}};
        vt[3] = '{OP_READ, 2'd1, RL_WORD, M0, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16, 1, '{{2'd3, 8'h40}, 10'h0, 10'h0}};
        vt[4] = '{OP_PROG, 2'd0, RL_MSB, M0, 16'hABCD, 1'b0, 1'b0, 16'h0000, 11, 2, '{{2'd3, 8'h20}, {2'd0, 8'hAB}, 10'h0}};
        vt[5] = '{OP_READ, 2'd0, RL_MSB, M0, 16'h0000, 1'b0, 1'b0, 16'h5A00, 11, 1, '{{2'd3, 8'h00}, 10'h0, 10'h0}};
        vt[6] = '{OP_PROG, 2'd2, RL_LSB, M5, 16'h00FF, 1'b0, 1'b0, 16'h0000, 11, 2, '{{2'd3, 8'h9A}, {2'd2, 8'hFF}, 10'h0}};
        vt[7] = '{OP_READ, 2'd2, RL_LSB, M0, 16'h0000, 1'b0, 1'b0, 16'h0088, 11, 1, '{{2'd3, 8'h80}, 10'h0, 10'h0}};
        vt[8] = '{OP_PROG, 2'd3, RL_WORD, M1, 16'h1111, 1'b0, 1'b1, 16'h0000, 1, 0, '{10'h0, 10'h0, 10'h0}};
        vt[9] = '{OP_READ, 2'd1, RL_LATCH, M4, 16'h2222, 1'b0, 1'b1, 16'h0000, 1, 0, '{10'h0, 10'h0, 10'h0}};
        bus.cmd_valid = 1'b0;
        drive(OP_PROG, 2'd0, RL_LSB, M0, 16'h0000);
        fork
            monitor();
            forever begin
                @(posedge clk);
                #1;
                cyc++;
                tce = tce_slow ? (cyc % 8 == 0) : 1'b1;
            end
            begin
                #2_000_000;
                $display("FAIL watchdog timeout");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #2;
        check("rst_wr", 32'(bus.pit_wr), 32'd0);
        check("rst_rd", 32'(bus.pit_rd), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_a", 32'(bus.pit_a), 32'd0);
        check("rst_din", 32'(bus.pit_din), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(i);

        // reset in the middle of the control-word strobe abandons the command
        tce_slow = 1'b0;
        @(posedge clk);
        #1;
        drive(OP_PROG, 2'd2, RL_WORD, M3, 16'h4321);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.pit_wr && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wr_before_reset", 32'(bus.pit_wr), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("wr_async_reset", 32'(bus.pit_wr), 32'd0);
        check("a_async_reset", 32'(bus.pit_a), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) pulses++;
        end
        check("no_rsp_after_abort", 32'(pulses), 32'd0);
        run_vec(0);

        // fields wiggle while busy; the follow-on command waits for cmd_ready
        wq.delete();
        @(posedge clk);
        #1;
        drive(OP_PROG, 2'd2, RL_WORD, M3, 16'h1234);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        while (!bus.rsp_valid && lat < 300) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 2'($urandom_range(1, 3)),
                  3'($urandom_range(0, 5)), 16'($urandom));
            check("busy_not_ready", 32'(bus.cmd_ready), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        drive(OP_PROG, 2'd1, RL_LSB, M0, 16'h0077);
        check("busy_latency", 32'(lat), 32'd16);
        check("busy_data", 32'(bus.rsp_data), 32'd0);
        check("busy_nwrites", 32'(wq.size()), 32'd3);
        for (int j = 0; j < 3; j++)
            check($sformatf("busy_write%0d", j), j < wq.size() ? 32'(wq[j]) : 32'hFFFF, 32'(vt[0].w[j]));
        @(posedge clk);
        #1;
        check("second_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_rsp(lat);
        check("second_latency", 32'(lat), 32'd11);
        check("second_err", 32'(bus.rsp_err), 32'd0);
        check("second_nwrites", 32'(wq.size()), 32'd5);
        check("second_cw", wq.size() > 3 ? 32'(wq[3]) : 32'hFFFF, 32'({2'd3, 8'h50}));
        check("second_lsb", wq.size() > 4 ? 32'(wq[4]) : 32'hFFFF, 32'({2'd1, 8'h77}));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
